// File: rtl/decimal_adder_sched.sv
// Round-robin sequencer for the shared multicycle decimal32 adder: grant, settle, capture, respond.
// Optional feature macro DEC_ADD_STICKY_FLAGS_EN adds sticky_flags/sticky_clr flag accumulation.
module decimal_adder_sched #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_op1,
    input  logic [32*NUM_REQ-1:0]  req_op2,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_result,
    output logic [3:0]             rsp_flags,
    output logic [31:0]            add_operand1,
    output logic [31:0]            add_operand2,
    input  logic [31:0]            add_result,
    input  logic [3:0]             add_flags,
    output logic                   busy
`ifdef DEC_ADD_STICKY_FLAGS_EN
    ,
    input  logic                   sticky_clr,
    output logic [3:0]             sticky_flags
`endif
);

    localparam int unsigned IdxW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

    state_e              state_q, state_d;
    logic [1:0]          rst_sync_q;
    logic                rst_int_n;
    logic [IdxW-1:0]     last_grant_q;
    logic [3:0]          cnt_q;
    logic [31:0]         op1_q, op2_q;
    logic [31:0]         result_q;
    logic [3:0]          flags_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;

    logic [31:0]         op1_arr [NUM_REQ];
    logic [31:0]         op2_arr [NUM_REQ];
    logic                grant_found;
    logic [IdxW-1:0]     grant_idx;
    logic [IdxW-1:0]     cand;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [NUM_REQ-1:0]  rsp_onehot;
    logic                handshake;
    logic                capture;

    // Assertion is asynchronous, release is delayed two clocks to avoid recovery hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op1_arr[g] = req_op1[32*g +: 32];
        assign op2_arr[g] = req_op2[32*g +: 32];
    end

    // First valid requester searching upward from the one after the last grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = last_grant_q;
        cand        = '0;
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            cand = IdxW'((int'(last_grant_q) + i) % int'(NUM_REQ));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_oh   = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    assign rsp_onehot = NUM_REQ'(1) << last_grant_q;
    assign handshake  = (state_q == StIdle) && grant_found && rst_int_n;
    assign capture    = (state_q == StSettle) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_found) state_d = StSettle;
            StSettle: if (cnt_q == '0) state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle:   req_ready = rst_int_n ? grant_oh : '0;
            StSettle: busy = 1'b1;
            StResp:   busy = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            last_grant_q <= IdxW'(NUM_REQ - 1);
            cnt_q        <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            rsp_valid_q  <= '0;
        end else begin
            if (handshake) begin
                op1_q        <= op1_arr[grant_idx];
                op2_q        <= op2_arr[grant_idx];
                last_grant_q <= grant_idx;
                cnt_q        <= 4'(SETTLE_CYCLES - 1);
            end
            if (state_q == StSettle && cnt_q != '0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                result_q    <= add_result;
                flags_q     <= add_flags;
                rsp_valid_q <= rsp_onehot;
            end
            if (state_q == StResp && rsp_ready) begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign add_operand1 = op1_q;
    assign add_operand2 = op2_q;
    assign rsp_result   = result_q;
    assign rsp_flags    = flags_q;
    assign rsp_valid    = rsp_valid_q;

`ifdef DEC_ADD_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    // A clear coinciding with a capture keeps only the newly captured flags.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sticky_q <= '0;
        end else if (capture) begin
            sticky_q <= sticky_clr ? add_flags : (sticky_q | add_flags);
        end else if (sticky_clr) begin
            sticky_q <= '0;
        end
    end

    assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_decimal_adder_sched.sv
// Directed bench for decimal_adder_sched with a binary-add stand-in for the decimal adder.
// Covers the DEC_ADD_STICKY_FLAGS_EN feature when that macro is defined.
module tb_decimal_adder_sched;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main DUT, SETTLE_CYCLES = 2
    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [63:0] req_op1, req_op2;
    logic        rsp_ready, busy;
    logic [31:0] rsp_result, add_operand1, add_operand2, add_result;
    logic [3:0]  rsp_flags, add_flags;

    // Throughput DUT, SETTLE_CYCLES = 3
    logic [1:0]  req_valid3, req_ready3, rsp_valid3;
    logic [63:0] req_op1_3, req_op2_3;
    logic        rsp_ready3, busy3;
    logic [31:0] rsp_result3, add_operand1_3, add_operand2_3, add_result3;
    logic [3:0]  rsp_flags3, add_flags3;

    assign add_result  = add_operand1 + add_operand2;
    assign add_flags   = add_operand1[3:0];
    assign add_result3 = add_operand1_3 + add_operand2_3;
    assign add_flags3  = add_operand1_3[3:0];

`ifdef DEC_ADD_STICKY_FLAGS_EN
    logic       sticky_clr, sticky_clr3;
    logic [3:0] sticky_flags, sticky_flags3;
`endif

    decimal_adder_sched #(.NUM_REQ(2), .SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .add_operand1(add_operand1), .add_operand2(add_operand2),
        .add_result(add_result), .add_flags(add_flags),
        .busy(busy)
`ifdef DEC_ADD_STICKY_FLAGS_EN
        , .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
`endif
    );

    decimal_adder_sched #(.NUM_REQ(2), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op1(req_op1_3), .req_op2(req_op2_3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_result(rsp_result3), .rsp_flags(rsp_flags3),
        .add_operand1(add_operand1_3), .add_operand2(add_operand2_3),
        .add_result(add_result3), .add_flags(add_flags3),
        .busy(busy3)
`ifdef DEC_ADD_STICKY_FLAGS_EN
        , .sticky_clr(sticky_clr3), .sticky_flags(sticky_flags3)
`endif
    );

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int rsp_any_cnt = 0;
    int r1_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rsp_valid != 2'b00) rsp_any_cnt <= rsp_any_cnt + 1;
        if (rsp_valid[1]) r1_cnt <= r1_cnt + 1;
    end

    typedef struct {
        int          req;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
    endtask

    // One full transaction on the main DUT with only requester r valid.
    task automatic run_txn(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eres, input logic [3:0] eflg, input string tag);
        int n;
        req_op1[32*r +: 32] = a;
        req_op2[32*r +: 32] = b;
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " grant"}, 32'(req_ready), 32'(1) << r);
        tick();
        req_valid = 2'b00;
        n = 1;
        while (rsp_valid == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, 3);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1) << r);
        chk({tag, " result"}, rsp_result, eres);
        chk({tag, " flags"}, 32'(rsp_flags), 32'(eflg));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " rsp clears"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t0;
        int tn;
        int r1_before;
        int any_before;
        int tput_t [8];

        vecs[0] = '{0, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 4'hF};
        vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'hF};
        vecs[2] = '{1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'h8};
        vecs[3] = '{0, 32'h8000_000A, 32'h8000_0000, 32'h0000_000A, 4'hA};
        vecs[4] = '{1, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'h3};

        rst_n = 1'b0;
        req_valid = '0; req_op1 = '0; req_op2 = '0; rsp_ready = 1'b0;
        req_valid3 = '0; req_op1_3 = '0; req_op2_3 = '0; rsp_ready3 = 1'b0;
`ifdef DEC_ADD_STICKY_FLAGS_EN
        sticky_clr = 1'b0;
        sticky_clr3 = 1'b0;
`endif
        tick();
        tick();
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset rsp_flags", 32'(rsp_flags), 0);
        chk("reset add_operand1", add_operand1, 0);
        chk("reset add_operand2", add_operand2, 0);
`ifdef DEC_ADD_STICKY_FLAGS_EN
        chk("reset sticky", 32'(sticky_flags), 0);
`endif
        rst_n = 1'b1;
        tick(); tick(); tick();

        // Single request, response held while rsp_ready stays low.
        req_op1[31:0] = 32'h0000_0005;
        req_op2[31:0] = 32'h0000_0003;
        req_valid = 2'b01;
        #1;
        chk("single grant", 32'(req_ready), 32'h1);
        chk("single idle busy", 32'(busy), 0);
        tick();
        req_valid = 2'b00;
        #1;
        chk("single settle busy", 32'(busy), 1);
        chk("single settle ready", 32'(req_ready), 0);
        chk("single operand1", add_operand1, 32'h5);
        chk("single operand2", add_operand2, 32'h3);
        tick();
        chk("single no early rsp", 32'(rsp_valid), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("hold rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold result", rsp_result, 32'h8);
            chk("hold flags", 32'(rsp_flags), 32'h5);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single rsp cleared", 32'(rsp_valid), 0);
        chk("single result retained", rsp_result, 32'h8);
        chk("single operand retained", add_operand1, 32'h5);
        chk("single back idle", 32'(busy), 0);

        // Table-driven single transactions.
        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].req, vecs[i].op1, vecs[i].op2, vecs[i].res, vecs[i].flg,
                    $sformatf("vec%0d", i));
        end

        // Simultaneous requests alternate 0,1,0,1,0 from reset.
        do_reset();
        req_op1 = {32'd10, 32'd1};
        req_op2 = {32'd20, 32'd1};
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("arb grant %0d", k), 32'(req_ready), 32'(exp_g));
            tick();
            n = 0;
            while (rsp_valid == 2'b00 && n < 20) begin
                tick();
                n++;
            end
            chk($sformatf("arb dest %0d", k), 32'(rsp_valid), 32'(exp_g));
            chk($sformatf("arb result %0d", k), rsp_result, (exp_g == 2'b01) ? 32'd2 : 32'd30);
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;

        // Requester 1 withdraws before it is ever granted.
        do_reset();
        r1_before = r1_cnt;
        req_op1[31:0] = 32'h7;
        req_op2[31:0] = 32'h1;
        req_valid = 2'b01;
        #1;
        chk("drop first grant", 32'(req_ready), 32'h1);
        tick();
        req_op1[63:32] = 32'd99;
        req_valid = 2'b10;
        #1;
        chk("drop no ready in settle", 32'(req_ready), 0);
        tick();
        req_valid = 2'b00;
        n = 0;
        while (rsp_valid == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk("drop first rsp", 32'(rsp_valid), 32'h1);
        chk("drop first result", rsp_result, 32'h8);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        run_txn(0, 32'h20, 32'h2, 32'h22, 4'h0, "drop regrant");
        repeat (8) tick();
        chk("drop req1 never answered", r1_cnt - r1_before, 0);

        // Reset pulse in SETTLE aborts the transaction.
        req_op1[31:0] = 32'h11;
        req_op2[31:0] = 32'h22;
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        chk("abort pre busy", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        chk("abort busy", 32'(busy), 0);
        chk("abort rsp_valid", 32'(rsp_valid), 0);
        chk("abort operand1", add_operand1, 0);
        chk("abort operand2", add_operand2, 0);
        chk("abort result", rsp_result, 0);
        chk("abort flags", 32'(rsp_flags), 0);
        any_before = rsp_any_cnt;
        rst_n = 1'b1;
        repeat (6) tick();
        chk("abort no rsp", rsp_any_cnt - any_before, 0);
        run_txn(1, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 4'h0, "post abort");

        // Back-to-back throughput on the SETTLE_CYCLES=3 instance.
        do_reset();
        req_op1_3[31:0] = 32'd3;
        req_op2_3[31:0] = 32'd4;
        rsp_ready3 = 1'b1;
        req_valid3 = 2'b01;
        t0 = cyc;
        tn = 0;
        for (int k = 0; k < 40; k++) begin
            if (rsp_valid3 != 2'b00 && tn < 8) begin
                tput_t[tn] = cyc;
                tn++;
            end
            tick();
        end
        req_valid3 = 2'b00;
        rsp_ready3 = 1'b0;
        chk("tput count", 32'(tn >= 4), 1);
        if (tn >= 4) begin
            chk("tput first latency", tput_t[0] - t0, 4);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("tput gap %0d", k), tput_t[k+1] - tput_t[k], 5);
            end
        end
        chk("tput result", rsp_result3, 32'd7);

`ifdef DEC_ADD_STICKY_FLAGS_EN
        do_reset();
        run_txn(0, 32'h1, 32'h0, 32'h1, 4'h1, "sticky a");
        run_txn(1, 32'h8, 32'h2, 32'hA, 4'h8, "sticky b");
        chk("sticky accumulated", 32'(sticky_flags), 32'h9);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("sticky cleared", 32'(sticky_flags), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decimal_adder_sched.md
# decimal_adder_sched

Sequencing and arbitration controller for the shared combinational decimal32 adder. Accepts add requests from up to four requesters over valid/ready handshakes and grants them round-robin. Registers the granted operands onto the adder inputs and waits a fixed settle time, because the adder is a long multicycle combinational path. It then captures result and flags and returns them on a shared response bus tagged by a one-hot valid.

## Interface
- NUM_REQ, 2: number of requesters, legal 2..4.
- SETTLE_CYCLES, 2: full cycles operands are held on the adder before capture, legal 1..15.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_op1  in  32*NUM_REQ  operand1 of requester i at [32i+31:32i].
- req_op2  in  32*NUM_REQ  operand2 of requester i, same packing.
- rsp_valid  out  NUM_REQ  one-hot response valid, identifies the destination requester.
- rsp_ready  in  1  response accepted by the addressed requester.
- rsp_result  out  32  captured adder Result.
- rsp_flags  out  4  captured adder Flags {invalid, overflow, underflow, inexact}.
- add_operand1  out  32  registered operand1 to the adder.
- add_operand2  out  32  registered operand2 to the adder.
- add_result  in  32  adder Result.
- add_flags  in  4  adder Flags.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, SETTLE and RESP.
- **IDLE**
  - If any req_valid is high, the grant goes to the first valid requester searching upward from (last_grant+1) mod NUM_REQ.
  - req_ready[grant] is asserted combinationally in the same cycle.
  - On the edge, add_operand1/2 load the granted operands, last_grant is updated, the counter loads SETTLE_CYCLES-1, and the FSM moves to SETTLE.
- **SETTLE**
  - The counter decrements each cycle.
  - When the counter is 0, add_result and add_flags are captured into rsp_result and rsp_flags on the edge. rsp_valid is set one-hot to the granted requester and the FSM moves to RESP.
- **RESP**
  - rsp_valid, rsp_result and rsp_flags are held stable until rsp_ready is high.
  - On that edge rsp_valid clears and the FSM returns to IDLE.
  - No new grant is made in RESP.
- req_ready is 0 in SETTLE and RESP.
- A requester may drop req_valid before it is granted; no commitment exists until the handshake.
- An accepted request is always answered, exactly once, in acceptance order.
- add_operand1/2 retain their last values after a transaction; they are not zeroed.
- rsp_result and rsp_flags hold their last captured values while rsp_valid is 0.

## Timing
- Reset values:
  - FSM is IDLE.
  - req_ready, rsp_valid and busy are 0.
  - rsp_result, rsp_flags, add_operand1 and add_operand2 are 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
- Latency:
  - Handshake occurs in cycle 0.
  - SETTLE occupies cycles 1..SETTLE_CYCLES, with capture at the end of cycle SETTLE_CYCLES.
  - rsp_valid is high from cycle SETTLE_CYCLES+1.
- Throughput: at most one add per SETTLE_CYCLES+2 cycles when rsp_ready is held high.
- Simultaneous requests: exactly one is granted, and the others wait with their valid held.
- The round-robin pointer advances only on a handshake.
- rst_n asserted mid-transaction aborts immediately: no response is issued and all state returns to reset values.
- rst_n deasserts synchronously inside the block, using a 2-flop release.

## Configuration
- DEC_ADD_STICKY_FLAGS_EN
  - When defined, adds output sticky_flags [3:0] and input sticky_clr [1].
  - sticky_flags ORs in add_flags at every capture edge. It clears to 0 on reset or when sticky_clr is high.
  - If sticky_clr and a capture occur on the same edge, the result is the captured flags only.
- When undefined, both ports and the register are absent, and behaviour is otherwise identical.

## Test plan
The bench models the adder as add_result = add_operand1 + add_operand2 (binary) and add_flags = add_operand1[3:0].
- Single request, SETTLE_CYCLES=2: req0 sends op1=32'h0000_0005, op2=32'h0000_0003 → rsp_valid=2'b01 in cycle 3, rsp_result=32'h0000_0008, rsp_flags=4'h5, held through 3 cycles of rsp_ready=0.
- Simultaneous req0 and req1 after reset → req0 is granted first and req1 second. With both held, the next grants alternate 0,1,0,1.
- req1 drops valid before grant, then only req0 is valid → req0 is granted, and no response is ever produced for req1.
- Back-to-back with rsp_ready tied high, SETTLE_CYCLES=3 → one response every 5 cycles.
- rst_n pulsed low during SETTLE → all outputs are 0 next cycle, no rsp_valid appears, and the next request completes normally.
- With the macro defined: two adds with add_flags 4'h1 then 4'h8 → sticky_flags=4'h9. Then sticky_clr=1 → 4'h0.
